fluxo_dados: RTL

- Datapath for the memory-game circuit. Sits directly downstream of unidade_controle's control outputs (zeraC, contaC, zeraR, registraR) and upstream of its status inputs (igual, fim, jogada).
- Holds the address counter, the fixed sequence ROM, the player-move register, the comparator and the button edge detector.
- Also drives debug outputs to the board displays.

---
 rtl/fluxo_dados_pkg.sv | 20 ++
 rtl/fluxo_dados_edge_detector.sv | 23 ++
 rtl/fluxo_dados.sv | 68 ++++++
 3 files changed

// File: rtl/fluxo_dados_pkg.sv
// Shared constants for the memory-game datapath: button count, sequence depth
// and the fixed move sequence stored in the ROM.
package fluxo_dados_pkg;

    localparam int FD_N     = 4;
    localparam int FD_DEPTH = 16;
    localparam int FD_CNT_W = $clog2(FD_DEPTH);

    typedef logic [FD_N-1:0]     jogada_t;
    typedef logic [FD_CNT_W-1:0] endereco_t;

    // Index 0 is the first move the player must repeat.
    localparam jogada_t FD_ROM [FD_DEPTH] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100,
        4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

endpackage

// File: rtl/fluxo_dados_edge_detector.sv
// Rising-edge pulse generator: pulso is high while sinal is set and was clear
// at the previous clock edge.
module fluxo_dados_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_p1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sinal_p1 <= 1'b0;
        end else begin
            sinal_p1 <= sinal;
        end
    end

    // Clearing history on reset lets a button held through reset release fire once.
    assign pulso = sinal & ~sinal_p1;

endmodule

// File: rtl/fluxo_dados.sv
// Memory-game datapath: address counter, fixed sequence ROM, player-move
// register, move comparator and button edge detector, plus debug taps.
module fluxo_dados
    import fluxo_dados_pkg::*;
#(
    parameter int N     = FD_N,
    parameter int DEPTH = FD_DEPTH,
    localparam int CNT_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     chaves,
    input  logic             zeraC,
    input  logic             contaC,
    input  logic             zeraR,
    input  logic             registraR,
    output logic             igual,
    output logic             fim,
    output logic             jogada,
    output logic [CNT_W-1:0] db_contagem,
    output logic [N-1:0]     db_memoria,
    output logic [N-1:0]     db_jogada
);

    logic [CNT_W-1:0] contagem;
    logic [N-1:0]     jogada_reg;
    logic [N-1:0]     rom_dado;
    logic             ativo;

    always_ff @(posedge clock) begin
        if (!reset) begin
            contagem <= '0;
        end else if (zeraC) begin
            contagem <= '0;
        end else if (contaC) begin
            contagem <= fim ? '0 : contagem + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            jogada_reg <= '0;
        end else if (zeraR) begin
            jogada_reg <= '0;
        end else if (registraR) begin
            jogada_reg <= chaves;
        end
    end

    assign rom_dado = FD_ROM[contagem];

    // Plain equality: a multi-button press stored in the register never matches.
    assign igual = (jogada_reg == rom_dado);
    assign fim   = (contagem == CNT_W'(DEPTH - 1));
    assign ativo = |chaves;

    fluxo_dados_edge_detector u_detector (
        .clock (clock),
        .reset (reset),
        .sinal (ativo),
        .pulso (jogada)
    );

    assign db_contagem = contagem;
    assign db_memoria  = rom_dado;
    assign db_jogada   = jogada_reg;

endmodule
